// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared types and constants for the RV32IM pipeline stall/flush sequencer.
//   state_e               : sequencer state (RUN / MD_WAIT)
//   MD_MAX_CYCLES_DEFAULT : default MUL/DIV watchdog limit in cycles
//   CNT_W_DEFAULT         : default width of the performance counters
//   CNT_ALL_ONES          : saturation value of a default-width counter
// Optional feature macro used by the top: PIPELINE_STALL_COUNTERS_EN
// ---------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam int MD_MAX_CYCLES_DEFAULT = 40;
  localparam int CNT_W_DEFAULT         = 32;
  localparam logic [CNT_W_DEFAULT-1:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/pipeline_sat_counter.sv
// ---------------------------------------------------------------------------
// pipeline_sat_counter
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clock_i : clock, rising edge
//   reset_i : asynchronous active-high reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count, sticks at all-ones once reached
// ---------------------------------------------------------------------------
module pipeline_sat_counter
  import pipeline_stall_controller_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q, count_d;

  // Count register; cleared asynchronously so it reads zero during reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Increment only below the ceiling so the value parks at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != MAX_VAL)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Central sequencer for the 5-stage pipeline register enables and flushes.
// Merges data-memory busy, the multi-cycle MUL/DIV handshake, taken
// branches from EX and ID-stage load-use hazards (in that priority order).
// Ports:
//   CLK, RESET              : clock (rising edge), async active-high reset
//   LU_HAZARD               : load-use hazard between ID and EX
//   BRANCH_TAKEN_EX         : EX instruction redirects the PC
//   MD_REQ_EX / MD_DONE     : MUL/DIV request in EX / one-cycle result valid
//   DMEM_BUSY               : data memory stalls the MEM stage
//   *_EN / *_FLUSH          : pipeline register load enables / bubble inserts
//   MD_GO                   : one-cycle start pulse to the MUL/DIV unit
//   MD_ERR                  : sticky MUL/DIV watchdog timeout
//   STALL_CYCLES/FLUSH_COUNT: performance counters
// Macro PIPELINE_STALL_COUNTERS_EN builds the counters; otherwise both
// counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MD_MAX_CYCLES = MD_MAX_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LU_HAZARD,
  input  logic             BRANCH_TAKEN_EX,
  input  logic             MD_REQ_EX,
  input  logic             MD_DONE,
  input  logic             DMEM_BUSY,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             MEM_WB_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic             MD_GO,
  output logic             MD_ERR,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  localparam int              WD_W     = $clog2(MD_MAX_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_MAX_CYCLES - 1);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wdCount_q, wdCount_d;
  logic            mdErr_q, mdErr_d;
  logic [WD_W-1:0] wdInc;
  logic            wdExpired;

  // The watchdog saturates, and ">=" keeps the timeout pending if memory
  // was busy on the exact cycle the limit was reached.
  assign wdInc     = (&wdCount_q) ? wdCount_q : wdCount_q + WD_W'(1);
  assign wdExpired = (wdCount_q >= WD_LIMIT);

  // State, watchdog and sticky error registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= RUN;
      wdCount_q <= '0;
      mdErr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdCount_q <= wdCount_d;
      mdErr_q   <= mdErr_d;
    end
  end

  // Next-state and pipeline controls. Defaults describe free flow; each
  // branch below overrides only what its stall or flush source needs.
  always_comb begin
    state_d      = state_q;
    wdCount_d    = wdCount_q;
    mdErr_d      = mdErr_q;
    PC_EN        = 1'b1;
    IF_ID_EN     = 1'b1;
    ID_EX_EN     = 1'b1;
    EX_MEM_EN    = 1'b1;
    MEM_WB_EN    = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    MD_GO        = 1'b0;

    if (RESET) begin
      PC_EN        = 1'b0;
      IF_ID_EN     = 1'b0;
      ID_EX_EN     = 1'b0;
      EX_MEM_EN    = 1'b0;
      MEM_WB_EN    = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
    end else if (DMEM_BUSY) begin
      // Full freeze; a MUL/DIV completion is still taken so it is not lost.
      PC_EN     = 1'b0;
      IF_ID_EN  = 1'b0;
      ID_EX_EN  = 1'b0;
      EX_MEM_EN = 1'b0;
      MEM_WB_EN = 1'b0;
      if (state_q == MD_WAIT) begin
        wdCount_d = wdInc;
        if (MD_DONE) begin
          state_d = RUN;
        end
      end
    end else begin
      unique case (state_q)
        MD_WAIT: begin
          if (MD_DONE || wdExpired) begin
            state_d = RUN;
            if (!MD_DONE) begin
              mdErr_d = 1'b1;
            end
          end else begin
            // Front end holds; EX/MEM takes bubbles so older work drains.
            PC_EN        = 1'b0;
            IF_ID_EN     = 1'b0;
            ID_EX_EN     = 1'b0;
            EX_MEM_FLUSH = 1'b1;
            wdCount_d    = wdInc;
          end
        end
        default: begin
          if (MD_REQ_EX) begin
            MD_GO     = 1'b1;
            PC_EN     = 1'b0;
            IF_ID_EN  = 1'b0;
            ID_EX_EN  = 1'b0;
            EX_MEM_EN = 1'b0;
            state_d   = MD_WAIT;
            wdCount_d = '0;
          end else if (BRANCH_TAKEN_EX) begin
            // The ID instruction is squashed, so any load-use hazard is moot.
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (LU_HAZARD) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_FLUSH = 1'b1;
          end
        end
      endcase
    end
  end

  assign MD_ERR = mdErr_q;

`ifdef PIPELINE_STALL_COUNTERS_EN
  logic stallInc, flushInc;

  assign stallInc = ~PC_EN & ~RESET;
  assign flushInc = (IF_ID_FLUSH | ID_EX_FLUSH) & ~RESET;

  pipeline_sat_counter #(.WIDTH(CNT_W)) uStallCounter (
    .clock_i (CLK),
    .reset_i (RESET),
    .inc_i   (stallInc),
    .count_o (STALL_CYCLES)
  );

  pipeline_sat_counter #(.WIDTH(CNT_W)) uFlushCounter (
    .clock_i (CLK),
    .reset_i (RESET),
    .inc_i   (flushInc),
    .count_o (FLUSH_COUNT)
  );
`else
  assign STALL_CYCLES = '0;
  assign FLUSH_COUNT  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Directed bench for pipeline_stall_controller: a table of single-cycle
// control vectors in RUN plus hand-written multi-cycle sequences for the
// MUL/DIV handshake, watchdog timeout, memory busy and async reset.
// Control outputs are packed as
//   {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
//    IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MD_GO}
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  localparam int TB_CNT_W  = 4;
  localparam int TB_MD_MAX = 40;

  localparam logic [8:0] V_IDLE = 9'b11111_000_0;
  localparam logic [8:0] V_LU   = 9'b00111_010_0;
  localparam logic [8:0] V_BR   = 9'b11111_110_0;
  localparam logic [8:0] V_HOLD = 9'b00000_000_0;
  localparam logic [8:0] V_GO   = 9'b00001_000_1;
  localparam logic [8:0] V_WAIT = 9'b00011_001_0;
  localparam logic [8:0] V_RST  = 9'b00000_111_0;

`ifdef PIPELINE_STALL_COUNTERS_EN
  localparam logic [31:0] EXP_CNT3  = 32'd3;
  localparam logic [31:0] EXP_CNT20 = 32'd15;
`else
  localparam logic [31:0] EXP_CNT3  = 32'd0;
  localparam logic [31:0] EXP_CNT20 = 32'd0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic LU_HAZARD, BRANCH_TAKEN_EX, MD_REQ_EX, MD_DONE, DMEM_BUSY;
  logic PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
  logic IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MD_GO, MD_ERR;
  logic [TB_CNT_W-1:0] STALL_CYCLES, FLUSH_COUNT;
  logic [8:0] ctrlVec;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       lu, br, req, done, busy;
    logic [8:0] expected;
  } vec_t;

  vec_t vecs[10];

  pipeline_stall_controller #(
    .MD_MAX_CYCLES (TB_MD_MAX),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .LU_HAZARD       (LU_HAZARD),
    .BRANCH_TAKEN_EX (BRANCH_TAKEN_EX),
    .MD_REQ_EX       (MD_REQ_EX),
    .MD_DONE         (MD_DONE),
    .DMEM_BUSY       (DMEM_BUSY),
    .PC_EN           (PC_EN),
    .IF_ID_EN        (IF_ID_EN),
    .ID_EX_EN        (ID_EX_EN),
    .EX_MEM_EN       (EX_MEM_EN),
    .MEM_WB_EN       (MEM_WB_EN),
    .IF_ID_FLUSH     (IF_ID_FLUSH),
    .ID_EX_FLUSH     (ID_EX_FLUSH),
    .EX_MEM_FLUSH    (EX_MEM_FLUSH),
    .MD_GO           (MD_GO),
    .MD_ERR          (MD_ERR),
    .STALL_CYCLES    (STALL_CYCLES),
    .FLUSH_COUNT     (FLUSH_COUNT)
  );

  assign ctrlVec = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
                    IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MD_GO};

  // 10 ns clock; inputs change just after the falling edge.
  always #5 CLK = ~CLK;

  // Drive all request inputs at once.
  task automatic applyStimulus(input logic lu, input logic br, input logic req,
                               input logic done, input logic busy);
    LU_HAZARD       = lu;
    BRANCH_TAKEN_EX = br;
    MD_REQ_EX       = req;
    MD_DONE         = done;
    DMEM_BUSY       = busy;
  endtask

  // Generic scalar comparison; every check in the bench funnels through here.
  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [8:0] expected);
    checkValue(name, {23'd0, ctrlVec}, {23'd0, expected});
  endtask

  // Issue a MUL/DIV request from RUN and check the start cycle.
  task automatic startMulDiv(input string tag);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput({tag, "_go"}, V_GO);
  endtask

  // Spend n idle cycles in MD_WAIT, checking the drain controls each cycle.
  task automatic waitCycles(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 checkOutput($sformatf("%s_wait%0d", tag, i), V_WAIT);
    end
  endtask

  initial begin
    vecs[0] = '{"idle",        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
    vecs[1] = '{"load_use",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
    vecs[2] = '{"branch",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BR};
    vecs[3] = '{"branch_lu",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_BR};
    vecs[4] = '{"busy",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V_HOLD};
    vecs[5] = '{"busy_br_lu",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, V_HOLD};
    vecs[6] = '{"md_req",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_GO};
    vecs[7] = '{"md_req_br",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V_GO};
    vecs[8] = '{"done_in_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_IDLE};
    vecs[9] = '{"busy_md_req", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, V_HOLD};

    // Reset state is visible while RESET is still high.
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_ctrl", V_RST);
    checkValue("reset_md_err", {31'd0, MD_ERR}, 32'd0);
    checkValue("reset_stall_cnt", {28'd0, STALL_CYCLES}, 32'd0);
    checkValue("reset_flush_cnt", {28'd0, FLUSH_COUNT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single-cycle vectors in RUN; inputs return to idle before each edge
    // so the MUL/DIV request rows never leave RUN.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i].lu, vecs[i].br, vecs[i].req, vecs[i].done, vecs[i].busy);
      #1 checkOutput(vecs[i].name, vecs[i].expected);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Load-use for one clocked cycle, then free flow again.
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_seq_stall", V_LU);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_seq_after", V_IDLE);

    // MUL/DIV with MD_DONE 33 cycles after the request.
    startMulDiv("md33");
    waitCycles("md33", 32);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("md33_release", V_IDLE);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("md33_after", V_IDLE);
    checkValue("md33_md_err", {31'd0, MD_ERR}, 32'd0);

    // MUL/DIV that never completes: release on the 41st cycle, sticky error.
    startMulDiv("wd");
    waitCycles("wd", TB_MD_MAX - 1);
    @(negedge CLK);
    #1 checkOutput("wd_release", V_IDLE);
    checkValue("wd_err_before_edge", {31'd0, MD_ERR}, 32'd0);
    @(negedge CLK);
    #1 checkOutput("wd_after", V_IDLE);
    checkValue("wd_err_set", {31'd0, MD_ERR}, 32'd1);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("wd_done_in_run", V_IDLE);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkValue("wd_err_sticky", {31'd0, MD_ERR}, 32'd1);

    // Memory busy during MD_WAIT freezes everything yet still takes MD_DONE.
    startMulDiv("busy");
    waitCycles("busy", 2);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("busy_in_wait", V_HOLD);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("busy_with_done", V_HOLD);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("busy_done_taken", V_IDLE);

    // Asynchronous reset in the middle of MD_WAIT, away from any clock edge.
    startMulDiv("rst");
    waitCycles("rst", 5);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 checkOutput("rst_async_ctrl", V_RST);
    checkValue("rst_async_md_err", {31'd0, MD_ERR}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1 checkOutput("rst_release", V_IDLE);
    @(negedge CLK);
    #1 checkOutput("rst_in_run", V_IDLE);

    // Held load-use hazard drives the stall and flush counters.
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    #1;
    checkValue("stall_cnt_3", {28'd0, STALL_CYCLES}, EXP_CNT3);
    checkValue("flush_cnt_3", {28'd0, FLUSH_COUNT}, EXP_CNT3);
    repeat (17) @(negedge CLK);
    #1;
    checkValue("stall_cnt_sat", {28'd0, STALL_CYCLES}, EXP_CNT20);
    checkValue("flush_cnt_sat", {28'd0, FLUSH_COUNT}, EXP_CNT20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the RV32IM 5-stage pipeline-register enables and flushes.
- Merges three stall/flush sources:
  - load-use hazard indication from the ID-stage hazard logic;
  - multi-cycle MUL/DIV start/done handshake;
  - taken-branch/jump redirect from EX.
- Also merges data-memory busy.
- Sits beside the hazard detection logic and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

Parameters:
- MD_MAX_CYCLES, 40, watchdog limit in cycles for a MUL/DIV operation before abort.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- LU_HAZARD  in  1  load-use hazard between the ID and EX instructions.
- BRANCH_TAKEN_EX  in  1  EX instruction redirects the PC.
- MD_REQ_EX  in  1  EX instruction is a multi-cycle MUL/DIV.
- MD_DONE  in  1  MUL/DIV result valid; single-cycle pulse.
- DMEM_BUSY  in  1  data memory cannot complete the MEM access this cycle.
- PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  register load enables.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1 each  load a bubble (NOP) instead of data.
- MD_GO  out  1  one-cycle start pulse to the MUL/DIV unit.
- MD_ERR  out  1  sticky watchdog-timeout flag.
- STALL_CYCLES, FLUSH_COUNT  out  CNT_W each  performance counters.

Behaviour:
- Reset: CLK, asynchronous active-high RESET.
  - state=RUN, watchdog counter=0, MD_ERR=0, counters=0.
  - While RESET is high: all *_EN=0, all *_FLUSH=1, MD_GO=0.
- States: RUN, MD_WAIT. Outputs are combinational from state and inputs; state is registered.
- Priority, highest first: DMEM_BUSY > MD_WAIT > BRANCH_TAKEN_EX > LU_HAZARD.
- DMEM_BUSY=1, any state:
  - all *_EN=0, all flushes=0, MD_GO=0;
  - no state change, except MD_DONE is still accepted in MD_WAIT;
  - the watchdog keeps counting.
- RUN with MD_REQ_EX=1:
  - MD_GO=1 for that cycle.
  - PC/IF_ID/ID_EX/EX_MEM enables=0, MEM_WB_EN=1.
  - Next state MD_WAIT; watchdog cleared.
- MD_WAIT:
  - PC/IF_ID/ID_EX hold (EN=0).
  - EX_MEM_EN=1 with EX_MEM_FLUSH=1, so older instructions drain.
  - MEM_WB_EN=1.
  - Watchdog increments each cycle.
- MD_WAIT exit on MD_DONE=1:
  - that cycle all enables=1, flushes=0; result is captured into EX/MEM;
  - next state RUN.
- MD_WAIT exit when watchdog reaches MD_MAX_CYCLES-1 without MD_DONE:
  - MD_ERR set (sticky until RESET);
  - same release as MD_DONE; next state RUN.
- MD_DONE while in RUN is ignored.
- RUN with BRANCH_TAKEN_EX=1:
  - all enables=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1;
  - LU_HAZARD ignored that cycle, since the ID instruction is squashed.
- RUN with LU_HAZARD=1 and no branch:
  - PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, remaining enables=1;
  - one bubble only; the hazard clears as the load advances.
- RUN, no events: all enables=1, all flushes=0.
- MD_REQ_EX and BRANCH_TAKEN_EX together: MD_REQ_EX has precedence (cannot legally co-occur).

Optional Feature:
- Macro: PIPELINE_STALL_COUNTERS_EN.
- Defined:
  - STALL_CYCLES increments every cycle PC_EN=0 and RESET=0;
  - FLUSH_COUNT increments every cycle IF_ID_FLUSH=1 or ID_EX_FLUSH=1 and RESET=0;
  - both saturate at all-ones.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Shared package holds:
  - state typedef: RUN=1'b0, MD_WAIT=1'b1;
  - the MD_MAX_CYCLES default constant;
  - a localparam for the counter all-ones value.
- One sub-module: pipeline_sat_counter (parameterised width, inc, saturating, async reset), instantiated twice under the macro.

Test Plan:
- RESET high mid-MD_WAIT after 5 cycles -> state RUN, MD_ERR=0, all EN=0, flushes=1 immediately without waiting for CLK; after release, all EN=1.
- LU_HAZARD=1 for 1 cycle in RUN -> that cycle PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1; next cycle all EN=1.
- MD_REQ_EX=1, MD_DONE pulsed 33 cycles later -> MD_GO=1 only in the first cycle; PC_EN=0 for 33 cycles; release on the MD_DONE cycle; MD_ERR=0.
- MD_REQ_EX=1, MD_DONE never (MD_MAX_CYCLES=40) -> release after 40 cycles, MD_ERR=1 and stays 1.
- BRANCH_TAKEN_EX=1 and LU_HAZARD=1 together -> PC_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1; DMEM_BUSY=1 on the same cycle instead -> all EN=0, all flushes=0.
- With PIPELINE_STALL_COUNTERS_EN and CNT_W=4: 20 stall cycles -> STALL_CYCLES=15 (saturated).
